// File: rtl/adxl_spi_reader.sv
// adxl_spi_reader: configures an ADXL345 over SPI mode 3, then periodically
// reads the X-axis sample, scales it by an arithmetic right shift and
// saturates it to a signed 8-bit value for the LED bar driver.
// Optional feature macro: ADXL_AVG_EN (average four reads per update).
// Handshake: valid_o is a one-cycle pulse, with no ready; data_o is
// meaningful in the pulse cycle and holds until the next pulse.
module adxl_spi_reader #(
    parameter int CLK_DIV       = 25,
    parameter int SAMPLE_CYCLES = 500000,
    parameter int SHIFT         = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    output logic       spi_cs_n_o,
    output logic       spi_sclk_o,
    output logic       spi_mosi_o,
    input  logic       spi_miso_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       busy_o,
    output logic       init_done_o,
    output logic [2:0] dbg_state_o
);
    localparam logic [2:0] S_INIT_WR1 = 3'd0;
    localparam logic [2:0] S_INIT_WR2 = 3'd1;
    localparam logic [2:0] S_IDLE     = 3'd2;
    localparam logic [2:0] S_READ     = 3'd3;
    localparam logic [2:0] S_UPDATE   = 3'd4;

    localparam logic [1:0] PH_SETUP = 2'd0;
    localparam logic [1:0] PH_LOW   = 2'd1;
    localparam logic [1:0] PH_HIGH  = 2'd2;

    localparam int DW = $clog2(CLK_DIV);
    localparam int GW = $clog2(2 * CLK_DIV + 1);
    localparam int TW = $clog2(SAMPLE_CYCLES + 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_INIT  = GW'(2 * CLK_DIV);
    localparam logic [TW-1:0] TIMER_END = TW'(SAMPLE_CYCLES - 1);

    logic [2:0]    state_q, state_d;
    logic [1:0]    ph_q, ph_d;
    logic [DW-1:0] div_q, div_d;
    logic [4:0]    bit_q, bit_d;
    logic [23:0]   tx_q, tx_d;
    logic [15:0]   rx_q, rx_d;
    logic          cs_q, cs_d, sclk_q, sclk_d, mosi_q, mosi_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d, init_done_q, init_done_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          first_q, first_d;
    logic          xfer_done, start;
    logic [23:0]   start_word;
    logic [4:0]    bit_last;
    logic signed [17:0] raw18;

`ifdef ADXL_AVG_EN
    logic signed [17:0] sum_q, sum_d, sum_nxt;
    logic [1:0]         cnt_q, cnt_d;
`endif

    // Bytes arrive X0 first, so the low byte sits in the upper half of rx_q.
    assign raw18 = {{2{rx_q[7]}}, rx_q[7:0], rx_q[15:8]};
    assign bit_last = (state_q == S_READ) ? 5'd23 : 5'd15;

    function automatic logic [7:0] sat8(input logic signed [17:0] v);
        logic signed [17:0] s;
        s = v >>> SHIFT;
        if (s > 18'sd127)       sat8 = 8'h7F;
        else if (s < -18'sd128) sat8 = 8'h80;
        else                    sat8 = s[7:0];
    endfunction

    // SPI bit engine, transaction sequencing, sample timer and output update.
    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        div_d       = div_q;
        bit_d       = bit_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        cs_d        = cs_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        init_done_d = init_done_q;
        first_d     = first_q;
        gap_d       = (gap_q != '0) ? gap_q - 1'b1 : gap_q;
        timer_d     = (timer_q == TIMER_END) ? timer_q : timer_q + 1'b1;
        xfer_done   = 1'b0;
        start       = 1'b0;
        start_word  = 24'h0;
`ifdef ADXL_AVG_EN
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        sum_nxt = sum_q + raw18;
`endif
        // Bit engine: runs only while CS is low; every phase lasts CLK_DIV clocks.
        if (!cs_q) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                if (ph_q == PH_LOW) begin
                    sclk_d = 1'b1;
                    rx_d   = {rx_q[14:0], spi_miso_i};
                    ph_d   = PH_HIGH;
                end else if (ph_q == PH_HIGH && bit_q == bit_last) begin
                    cs_d      = 1'b1;
                    mosi_d    = 1'b0;
                    gap_d     = GAP_INIT;
                    xfer_done = 1'b1;
                end else begin
                    sclk_d = 1'b0;
                    mosi_d = tx_q[23];
                    tx_d   = {tx_q[22:0], 1'b0};
                    ph_d   = PH_LOW;
                    if (ph_q == PH_HIGH) bit_d = bit_q + 1'b1;
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end

        case (state_q)
            S_INIT_WR1: begin
                if (cs_q) begin
                    start      = 1'b1;
                    start_word = {16'h3108, 8'h00};
                end
                if (xfer_done) state_d = S_INIT_WR2;
            end
            S_INIT_WR2: begin
                if (cs_q && gap_q == '0) begin
                    start      = 1'b1;
                    start_word = {16'h2D08, 8'h00};
                end
                if (xfer_done) begin
                    state_d     = S_IDLE;
                    init_done_d = 1'b1;
                end
            end
            S_IDLE: begin
                if (en_i && gap_q == '0 && (!first_q || timer_q == TIMER_END)) begin
                    start      = 1'b1;
                    start_word = 24'hF20000;
                    timer_d    = '0;
                    first_d    = 1'b1;
                    state_d    = S_READ;
                end
            end
            S_READ: begin
                if (xfer_done) state_d = S_UPDATE;
            end
            S_UPDATE: begin
`ifdef ADXL_AVG_EN
                if (cnt_q == 2'd3) begin
                    data_d  = sat8(sum_nxt >>> 2);
                    valid_d = 1'b1;
                    sum_d   = '0;
                    cnt_d   = 2'd0;
                end else begin
                    sum_d = sum_nxt;
                    cnt_d = cnt_q + 1'b1;
                end
`else
                data_d  = sat8(raw18);
                valid_d = 1'b1;
`endif
                state_d = S_IDLE;
            end
            default: state_d = S_INIT_WR1;
        endcase

        if (start) begin
            cs_d   = 1'b0;
            sclk_d = 1'b1;
            mosi_d = 1'b0;
            ph_d   = PH_SETUP;
            div_d  = '0;
            bit_d  = '0;
            tx_d   = start_word;
        end
    end

    // State registers; reset is asynchronous and abandons any transaction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_INIT_WR1;
            ph_q        <= PH_SETUP;
            div_q       <= '0;
            bit_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            cs_q        <= 1'b1;
            sclk_q      <= 1'b1;
            mosi_q      <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            init_done_q <= 1'b0;
            gap_q       <= '0;
            timer_q     <= '0;
            first_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            cs_q        <= cs_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            init_done_q <= init_done_d;
            gap_q       <= gap_d;
            timer_q     <= timer_d;
            first_q     <= first_d;
        end
    end

`ifdef ADXL_AVG_EN
    // Four-read accumulator and read counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sum_q <= '0;
            cnt_q <= '0;
        end else begin
            sum_q <= sum_d;
            cnt_q <= cnt_d;
        end
    end
`endif

    assign spi_cs_n_o  = cs_q;
    assign spi_sclk_o  = sclk_q;
    assign spi_mosi_o  = mosi_q;
    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign busy_o      = ~cs_q;
    assign init_done_o = init_done_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_adxl_spi_reader.sv
// Directed bench for adxl_spi_reader with a behavioural ADXL345 SPI model.
// Optional feature macro: ADXL_AVG_EN selects the four-read averaging run.
module tb_adxl_spi_reader;
    localparam int CLK_DIV = 4;
    localparam int SAMPLE  = 2000;
`ifdef ADXL_AVG_EN
    localparam int SHIFT_P = 0;
`else
    localparam int SHIFT_P = 2;
`endif

    logic       clk = 1'b0;
    logic       rst_i, en_i;
    logic       spi_cs_n_o, spi_sclk_o, spi_mosi_o;
    logic       spi_miso_i = 1'b0;
    logic [7:0] data_o;
    logic       valid_o, busy_o, init_done_o;
    logic [2:0] dbg_state_o;

    int checks = 0;
    int errors = 0;

    adxl_spi_reader #(.CLK_DIV(CLK_DIV), .SAMPLE_CYCLES(SAMPLE), .SHIFT(SHIFT_P)) dut (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i),
        .spi_cs_n_o(spi_cs_n_o), .spi_sclk_o(spi_sclk_o), .spi_mosi_o(spi_mosi_o),
        .spi_miso_i(spi_miso_i), .data_o(data_o), .valid_o(valid_o),
        .busy_o(busy_o), .init_done_o(init_done_o), .dbg_state_o(dbg_state_o)
    );

    // Clock: 10 ns period, DUT acts on rising edges, bench samples on falling.
    always #5 clk = ~clk;

    // Sensor model: shifts out {dummy, X0, X1} and captures MOSI per transaction.
    logic [7:0]  x0 = 8'h00, x1 = 8'h00;
    logic [23:0] miso_word = 24'h0, mosi_sr = 24'h0, cap_word = 24'h0;
    int          rx_cnt = 0, cap_bits = 0, xfer_cnt = 0, cs_falls = 0, fall_idx = 0, sclk_bad = 0;
    time         fall_t = 0, prev_fall_t = 0, last_edge = 0;

    always @(negedge spi_cs_n_o) begin
        rx_cnt      = 0;
        fall_idx    = 0;
        mosi_sr     = 24'h0;
        miso_word   = {8'h00, x0, x1};
        prev_fall_t = fall_t;
        fall_t      = $time;
        last_edge   = $time;
        cs_falls++;
    end

    always @(negedge spi_sclk_o) begin
        if (spi_cs_n_o === 1'b0) begin
            if ($time - last_edge != CLK_DIV * 10) sclk_bad++;
            last_edge  = $time;
            fall_idx++;
            spi_miso_i = miso_word[23];
            miso_word  = {miso_word[22:0], 1'b0};
        end
    end

    always @(posedge spi_sclk_o) begin
        if (spi_cs_n_o === 1'b0) begin
            if ($time - last_edge != CLK_DIV * 10) sclk_bad++;
            last_edge = $time;
            mosi_sr   = {mosi_sr[22:0], spi_mosi_o};
            rx_cnt++;
        end
    end

    always @(posedge spi_cs_n_o) begin
        if (rx_cnt > 0) begin
            cap_word = mosi_sr;
            cap_bits = rx_cnt;
            xfer_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wait for the end of the next transaction (CS rise), bounded.
    task automatic wait_xfer(input string tag);
        int old = xfer_cnt;
        int n = 0;
        while (xfer_cnt == old && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, 32'(xfer_cnt != old), 32'd1);
    endtask

    // Wait for the next CS fall, bounded.
    task automatic wait_cs_fall(input string tag);
        int old = cs_falls;
        int n = 0;
        while (cs_falls == old && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_start"}, 32'(cs_falls != old), 32'd1);
    endtask

    task automatic chk_write(input string tag, input logic [15:0] word);
        wait_xfer(tag);
        chk({tag, "_bits"}, 32'(cap_bits), 32'd16);
        chk({tag, "_word"}, {16'h0, cap_word[15:0]}, {16'h0, word});
    endtask

    // One READ: present raw, check framing, period and the valid pulse timing.
    task automatic do_read(input string tag, input logic [15:0] raw, input logic [7:0] exp,
                           input bit chk_period);
        x0 = raw[7:0];
        x1 = raw[15:8];
        wait_cs_fall(tag);
        if (chk_period) chk({tag, "_period"}, 32'(fall_t - prev_fall_t), 32'(SAMPLE * 10));
        chk({tag, "_busy"}, {31'h0, busy_o}, 32'd1);
        wait_xfer(tag);
        chk({tag, "_bits"}, 32'(cap_bits), 32'd24);
        chk({tag, "_cmd"}, {8'h0, cap_word}, 32'h00F20000);
        chk({tag, "_valid_early"}, {31'h0, valid_o}, 32'd0);
        @(negedge clk);
        chk({tag, "_valid"}, {31'h0, valid_o}, 32'd1);
        chk({tag, "_data"}, {24'h0, data_o}, {24'h0, exp});
        @(negedge clk);
        chk({tag, "_valid_end"}, {31'h0, valid_o}, 32'd0);
        chk({tag, "_hold"}, {24'h0, data_o}, {24'h0, exp});
    endtask

    initial begin
        int n0;
        int n;
        rst_i = 1'b1;
        en_i  = 1'b1;
        #23;
        chk("rst_cs", {31'h0, spi_cs_n_o}, 32'd1);
        chk("rst_sclk", {31'h0, spi_sclk_o}, 32'd1);
        chk("rst_mosi", {31'h0, spi_mosi_o}, 32'd0);
        chk("rst_data", {24'h0, data_o}, 32'd0);
        chk("rst_valid", {31'h0, valid_o}, 32'd0);
        chk("rst_busy", {31'h0, busy_o}, 32'd0);
        chk("rst_init", {31'h0, init_done_o}, 32'd0);
        @(negedge clk);
        rst_i = 1'b0;

        chk_write("wr1", 16'h3108);
        chk("init_after_wr1", {31'h0, init_done_o}, 32'd0);
        chk_write("wr2", 16'h2D08);
        chk("init_after_wr2", {31'h0, init_done_o}, 32'd1);

`ifdef ADXL_AVG_EN
        for (int i = 0; i < 3; i++) begin
            x0 = 8'(4 * (i + 1));
            x1 = 8'h00;
            wait_cs_fall("avg_rd");
            wait_xfer("avg_rd");
            repeat (3) begin
                @(negedge clk);
                chk("avg_no_valid", {31'h0, valid_o}, 32'd0);
            end
        end
        do_read("avg_rd4", 16'd16, 8'h0A, 1'b1);
`else
        do_read("rd_pos", 16'h0040, 8'h10, 1'b0);
        do_read("rd_neg", 16'hFFF0, 8'hFC, 1'b1);
        do_read("rd_max", 16'h7FFF, 8'h7F, 1'b1);
        do_read("rd_min", 16'h8000, 8'h80, 1'b1);
        do_read("rd_127", 16'h01FC, 8'h7F, 1'b1);
        do_read("rd_m128", 16'hFE00, 8'h80, 1'b1);
        chk("sclk_half_periods", 32'(sclk_bad), 32'd0);

        // Drop en_i mid-READ: the read still completes, then nothing starts.
        x0 = 8'h00;
        x1 = 8'h01;
        wait_cs_fall("en_drop");
        repeat (50) @(negedge clk);
        en_i = 1'b0;
        wait_xfer("en_drop");
        @(negedge clk);
        chk("en_drop_valid", {31'h0, valid_o}, 32'd1);
        chk("en_drop_data", {24'h0, data_o}, 32'h40);
        n0 = cs_falls;
        repeat (3000) @(negedge clk);
        chk("en_drop_no_start", 32'(cs_falls), 32'(n0));

        // Reset during the 5th bit of a READ.
        en_i = 1'b1;
        wait_cs_fall("abort");
        n = 0;
        while (fall_idx < 5 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached_bit5", 32'(fall_idx), 32'd5);
        rst_i = 1'b1;
        #1;
        chk("abort_cs", {31'h0, spi_cs_n_o}, 32'd1);
        chk("abort_sclk", {31'h0, spi_sclk_o}, 32'd1);
        chk("abort_data", {24'h0, data_o}, 32'd0);
        chk("abort_busy", {31'h0, busy_o}, 32'd0);
        @(negedge clk);
        rst_i = 1'b0;
        chk("abort_init", {31'h0, init_done_o}, 32'd0);
        chk_write("re_wr1", 16'h3108);
        chk_write("re_wr2", 16'h2D08);
        do_read("re_rd", 16'h0040, 8'h10, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
